dmem_port_arbiter: RTL and testbench



---
 rtl/dmem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous data-memory port among NUM_REQ requesters.
// Define ARB_FIXED_PRIORITY_EN to replace round-robin with lowest-index-wins priority.
module dmem_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ-1:0]             req_wr,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]             gnt,
   output logic [NUM_REQ-1:0]             rvalid,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic                           busy,
   output logic                           mem_enable,
   output logic                           store_enable,
   output logic [ADDR_WIDTH-1:0]          dmem_address,
   output logic [DATA_WIDTH-1:0]          dmem_dataIn,
   input  logic [DATA_WIDTH-1:0]          dmem_dataOut
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = $clog2(RD_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t                 state, state_n;
   logic [IDW-1:0]         lat_id, lat_id_n, win_id;
   logic                   lat_wr, lat_wr_n;
   logic [CW-1:0]          cnt, cnt_n;
   logic [NUM_REQ-1:0]     gnt_n, rvalid_n;
   logic [DATA_WIDTH-1:0]  rdata_n, dmem_dataIn_n;
   logic [ADDR_WIDTH-1:0]  dmem_address_n;
   logic                   busy_n, mem_enable_n, store_enable_n;

`ifdef ARB_FIXED_PRIORITY_EN
   // Lowest set index wins; scanning downward lets the lowest overwrite the rest.
   always_comb begin
      win_id = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) win_id = IDW'(i);
      end
   end
`else
   logic [IDW-1:0] rr_ptr, rr_ptr_n, scan_id;
   logic           found;

   // First set request at or after rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      win_id  = '0;
      found   = 1'b0;
      scan_id = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (int'(rr_ptr) + k >= NUM_REQ) scan_id = IDW'(int'(rr_ptr) + k - NUM_REQ);
         else                             scan_id = IDW'(int'(rr_ptr) + k);
         if (!found && req[scan_id]) begin
            win_id = scan_id;
            found  = 1'b1;
         end
      end
   end
`endif

   // Every output is a register; this block computes the value each one takes next edge.
   always_comb begin
      state_n        = state;
      lat_id_n       = lat_id;
      lat_wr_n       = lat_wr;
      cnt_n          = cnt;
      gnt_n          = '0;
      rvalid_n       = '0;
      rdata_n        = rdata;
      busy_n         = 1'b0;
      mem_enable_n   = 1'b0;
      store_enable_n = 1'b0;
      dmem_address_n = dmem_address;
      dmem_dataIn_n  = dmem_dataIn;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_ptr_n       = rr_ptr;
`endif
      case (state)
         IDLE: begin
            if (|req) begin
               lat_id_n       = win_id;
               lat_wr_n       = req_wr[win_id];
               dmem_address_n = req_addr[int'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];
               dmem_dataIn_n  = req_wdata[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
               gnt_n[win_id]  = 1'b1;
               mem_enable_n   = 1'b1;
               store_enable_n = req_wr[win_id];
               busy_n         = 1'b1;
               state_n        = ISSUE;
            end
         end
         ISSUE: begin
`ifndef ARB_FIXED_PRIORITY_EN
            rr_ptr_n = (lat_id == IDW'(NUM_REQ - 1)) ? '0 : lat_id + 1'b1;
`endif
            if (lat_wr) begin
               state_n = IDLE;
            end else begin
               cnt_n   = CW'(RD_LATENCY);
               busy_n  = 1'b1;
               state_n = WAIT;
            end
         end
         WAIT: begin
            // The memory data is valid during the cycle in which the count sits at one.
            if (cnt == CW'(1)) begin
               rdata_n          = dmem_dataOut;
               rvalid_n[lat_id] = 1'b1;
               state_n          = IDLE;
            end else begin
               cnt_n  = cnt - 1'b1;
               busy_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         lat_id       <= '0;
         lat_wr       <= 1'b0;
         cnt          <= '0;
         gnt          <= '0;
         rvalid       <= '0;
         rdata        <= '0;
         busy         <= 1'b0;
         mem_enable   <= 1'b0;
         store_enable <= 1'b0;
         dmem_address <= '0;
         dmem_dataIn  <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
         rr_ptr       <= '0;
`endif
      end else begin
         state        <= state_n;
         lat_id       <= lat_id_n;
         lat_wr       <= lat_wr_n;
         cnt          <= cnt_n;
         gnt          <= gnt_n;
         rvalid       <= rvalid_n;
         rdata        <= rdata_n;
         busy         <= busy_n;
         mem_enable   <= mem_enable_n;
         store_enable <= store_enable_n;
         dmem_address <= dmem_address_n;
         dmem_dataIn  <= dmem_dataIn_n;
`ifndef ARB_FIXED_PRIORITY_EN
         rr_ptr       <= rr_ptr_n;
`endif
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: directed scenarios, then random traffic checked against
// a transaction-timeline model. Honours ARB_FIXED_PRIORITY_EN when defined.
module tb_dmem_port_arbiter;

   localparam int N    = 4;
   localparam int DW   = 64;
   localparam int AW   = 32;
   localparam int RL   = 3;
   localparam int MAXC = 4096;

   logic            clk, rst;
   logic [N-1:0]    req, req_wr, gnt, rvalid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   rdata, dmem_dataIn, dmem_dataOut;
   logic            busy, mem_enable, store_enable;
   logic [AW-1:0]   dmem_address;

   dmem_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RL)) dut (
      .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
      .mem_enable(mem_enable), .store_enable(store_enable), .dmem_address(dmem_address),
      .dmem_dataIn(dmem_dataIn), .dmem_dataOut(dmem_dataOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory with RL cycles of read latency; idle cycles return noise.
   logic          mem_init;
   logic [DW-1:0] mem  [256];
   logic [DW-1:0] pipe [RL];

   function automatic logic [DW-1:0] init_val(int i);
      logic [7:0] b;
      b = 8'(i) ^ 8'h41;
      return {32'hDEADBEEF, 24'h0, b};
   endfunction

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      end else if (mem_enable && store_enable) begin
         mem[dmem_address[7:0]] <= dmem_dataIn;
      end
      pipe[0] <= (mem_enable && !store_enable) ? mem[dmem_address[7:0]] : {$urandom, $urandom};
      for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
   end
   assign dmem_dataOut = pipe[RL-1];

   // Expected outputs per cycle, filled in when an arbitration is predicted.
   int            cyc, free_c, ptr, checks, failures;
   logic [N-1:0]  e_gnt [MAXC];
   logic [N-1:0]  e_rvalid [MAXC];
   logic          e_me [MAXC];
   logic          e_se [MAXC];
   logic          e_busy [MAXC];
   logic          e_rdu [MAXC];
   logic [AW-1:0] e_addr [MAXC];
   logic [DW-1:0] e_wdata [MAXC];
   logic [DW-1:0] e_rdv [MAXC];
   logic [DW-1:0] shadow [256];
   logic [DW-1:0] cur_rdata;
   logic [N-1:0]  gnt_log [$];
   logic [DW-1:0] rd_log [$];

   logic          cmd_wr [N];
   logic [AW-1:0] cmd_addr [N];
   logic [DW-1:0] cmd_data [N];
   logic [N-1:0]  rq;

   task automatic clearExp(input int c);
      e_gnt[c] = '0; e_rvalid[c] = '0; e_me[c] = 1'b0; e_se[c] = 1'b0;
      e_busy[c] = 1'b0; e_rdu[c] = 1'b0; e_addr[c] = '0; e_wdata[c] = '0; e_rdv[c] = '0;
   endtask

   task automatic setCmd(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cmd_wr[i] = wr; cmd_addr[i] = a; cmd_data[i] = d;
   endtask

   task automatic newCmd(input int i);
      setCmd(i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)) << 3, {$urandom, $urandom});
   endtask

   // Inputs driven during cycle n are sampled at the next edge; results appear from cycle n+1.
   task automatic modelStep();
      int n, w;
      n = cyc;
      w = -1;
      if (rst) begin
         for (int c = n + 1; c <= n + RL + 3; c++) clearExp(c);
         e_rdu[n+1] = 1'b1;
         ptr        = 0;
         free_c     = n + 1;
      end else if (n >= free_c && req != '0) begin
`ifdef ARB_FIXED_PRIORITY_EN
         for (int i = N - 1; i >= 0; i--) if (req[i]) w = i;
`else
         for (int k = N - 1; k >= 0; k--) if (req[(ptr + k) % N]) w = (ptr + k) % N;
`endif
         e_gnt[n+1]   = N'(1) << w;
         e_me[n+1]    = 1'b1;
         e_se[n+1]    = cmd_wr[w];
         e_addr[n+1]  = cmd_addr[w];
         e_wdata[n+1] = cmd_data[w];
         e_busy[n+1]  = 1'b1;
         if (cmd_wr[w]) begin
            shadow[cmd_addr[w][7:0]] = cmd_data[w];
            free_c = n + 2;
         end else begin
            for (int c = n + 2; c <= n + 1 + RL; c++) e_busy[c] = 1'b1;
            e_rvalid[n+2+RL] = N'(1) << w;
            e_rdu[n+2+RL]    = 1'b1;
            e_rdv[n+2+RL]    = shadow[cmd_addr[w][7:0]];
            free_c = n + 2 + RL;
         end
         ptr = (w + 1) % N;
      end
   endtask

   task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic checkOutput();
      if (e_rdu[cyc]) cur_rdata = e_rdv[cyc];
      cmp("gnt", 64'(gnt), 64'(e_gnt[cyc]));
      cmp("rvalid", 64'(rvalid), 64'(e_rvalid[cyc]));
      cmp("busy", 64'(busy), 64'(e_busy[cyc]));
      cmp("mem_enable", 64'(mem_enable), 64'(e_me[cyc]));
      cmp("store_enable", 64'(store_enable), 64'(e_se[cyc]));
      cmp("rdata", rdata, cur_rdata);
      if (e_me[cyc]) begin
         cmp("dmem_address", 64'(dmem_address), 64'(e_addr[cyc]));
         cmp("dmem_dataIn", dmem_dataIn, e_wdata[cyc]);
      end
      if (gnt != '0) gnt_log.push_back(gnt);
      if (rvalid != '0) rd_log.push_back(rdata);
   endtask

   task automatic applyStimulus(input logic r, input logic [N-1:0] rqv);
      rst = r;
      req = rqv;
      for (int i = 0; i < N; i++) begin
         req_wr[i]              = cmd_wr[i];
         req_addr[i*AW +: AW]   = cmd_addr[i];
         req_wdata[i*DW +: DW]  = cmd_data[i];
      end
      modelStep();
      @(posedge clk);
      #1;
      cyc++;
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0);
   endtask

   task automatic clearLogs();
      gnt_log.delete();
      rd_log.delete();
   endtask

   initial begin
      checks = 0; failures = 0; cyc = 0; free_c = 0; ptr = 0; cur_rdata = '0;
      for (int c = 0; c < MAXC; c++) clearExp(c);
      for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
      for (int i = 0; i < N; i++) setCmd(i, 1'b0, '0, '0);
      rq = '0;
      rst = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
      mem_init = 1'b1;

      applyStimulus(1'b1, '0);
      mem_init = 1'b0;
      applyStimulus(1'b1, '0);

      // Single load from requester 1.
      clearLogs();
      setCmd(1, 1'b0, 32'h40, '0);
      applyStimulus(1'b0, 4'b0010);
      idle(RL + 3);
      cmp("load_gnt", 64'(gnt_log[0]), 64'h2);
      cmp("load_rvalid_count", 64'(rd_log.size()), 64'd1);
      cmp("load_rdata", rd_log[0], 64'hDEADBEEF_00000001);

      // Single store from requester 0, then read it back.
      clearLogs();
      setCmd(0, 1'b1, 32'h10, 64'h1234);
      applyStimulus(1'b0, 4'b0001);
      idle(3);
      cmp("store_gnt", 64'(gnt_log[0]), 64'h1);
      cmp("store_no_rvalid", 64'(rd_log.size()), 64'd0);
      setCmd(0, 1'b0, 32'h10, '0);
      applyStimulus(1'b0, 4'b0001);
      idle(RL + 3);
      cmp("store_readback", rd_log[0], 64'h1234);

      // All four storing continuously from reset.
      applyStimulus(1'b1, '0);
      clearLogs();
      for (int i = 0; i < N; i++) setCmd(i, 1'b1, 32'(8 * (i + 1)), {$urandom, $urandom});
      for (int s = 0; s < 10; s++) applyStimulus(1'b0, 4'b1111);
      idle(2);
      cmp("all_gnt_count", 64'(gnt_log.size()), 64'd5);
`ifdef ARB_FIXED_PRIORITY_EN
      for (int g = 0; g < 5; g++) cmp("all_gnt_seq", 64'(gnt_log[g]), 64'h1);
`else
      cmp("all_gnt_seq0", 64'(gnt_log[0]), 64'h1);
      cmp("all_gnt_seq1", 64'(gnt_log[1]), 64'h2);
      cmp("all_gnt_seq2", 64'(gnt_log[2]), 64'h4);
      cmp("all_gnt_seq3", 64'(gnt_log[3]), 64'h8);
      cmp("all_gnt_seq4", 64'(gnt_log[4]), 64'h1);
`endif

      // Requesters 1 and 3 compete after a grant to 1 moved the pointer to 2.
      applyStimulus(1'b1, '0);
      clearLogs();
      setCmd(1, 1'b1, 32'h20, {$urandom, $urandom});
      applyStimulus(1'b0, 4'b0010);
      applyStimulus(1'b0, '0);
      setCmd(3, 1'b1, 32'h28, {$urandom, $urandom});
      for (int s = 0; s < 4; s++) applyStimulus(1'b0, 4'b1010);
      idle(2);
      cmp("rr13_count", 64'(gnt_log.size()), 64'd3);
`ifdef ARB_FIXED_PRIORITY_EN
      cmp("rr13_first", 64'(gnt_log[1]), 64'h2);
      cmp("rr13_second", 64'(gnt_log[2]), 64'h2);
`else
      cmp("rr13_first", 64'(gnt_log[1]), 64'h8);
      cmp("rr13_second", 64'(gnt_log[2]), 64'h2);
`endif

      // Reset during WAIT abandons the load and clears the pointer.
      applyStimulus(1'b1, '0);
      clearLogs();
      setCmd(0, 1'b0, 32'h48, '0);
      applyStimulus(1'b0, 4'b0001);
      applyStimulus(1'b0, '0);
      applyStimulus(1'b1, '0);
      cmp("rstwait_busy", 64'(busy), 64'd0);
      setCmd(0, 1'b1, 32'h30, {$urandom, $urandom});
      setCmd(2, 1'b1, 32'h38, {$urandom, $urandom});
      applyStimulus(1'b0, 4'b0101);
      applyStimulus(1'b0, '0);
      setCmd(3, 1'b0, 32'h30, '0);
      applyStimulus(1'b0, 4'b1000);
      idle(RL + 3);
      cmp("rstwait_gnt_after", 64'(gnt_log[1]), 64'h1);
      cmp("rstwait_gnt3", 64'(gnt_log[2]), 64'h8);
      cmp("rstwait_rvalid_count", 64'(rd_log.size()), 64'd1);

      // Requester 2 pulses req for one cycle while a load waits.
      clearLogs();
      setCmd(0, 1'b0, 32'h50, '0);
      applyStimulus(1'b0, 4'b0001);
      applyStimulus(1'b0, '0);
      setCmd(2, 1'b0, 32'h58, '0);
      applyStimulus(1'b0, 4'b0100);
      idle(RL + 3);
      cmp("pulse_gnt_count", 64'(gnt_log.size()), 64'd1);
      cmp("pulse_busy", 64'(busy), 64'd0);

      // Random traffic with occasional resets.
      for (int s = 0; s < 800; s++) begin
         for (int i = 0; i < N; i++) begin
            if (!rq[i]) begin
               if ($urandom_range(0, 99) < 30) begin
                  rq[i] = 1'b1;
                  newCmd(i);
               end
            end else if (gnt[i]) begin
               if ($urandom_range(0, 1) == 0) rq[i] = 1'b0;
               else newCmd(i);
            end else if ($urandom_range(0, 99) < 5) begin
               rq[i] = 1'b0;
            end
         end
         applyStimulus($urandom_range(0, 99) == 0, rq);
      end
      idle(RL + 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
